// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction-decode stage of the five-stage MIPS pipeline.
//                Holds the 32x32 register file (with write-through forwarding
//                from write-back), sign-extends the immediate, decodes the
//                main control word and captures everything into ID/EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_ir,
    input  logic [31:0] if_id_npc,
    input  logic        flush,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_wreg,
    input  logic [31:0] wb_wdata,
    output logic [31:0] id_ex_npc,
    output logic [31:0] id_ex_a,
    output logic [31:0] id_ex_b,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_rd,
    output logic [1:0]  id_ex_wb,
    output logic [2:0]  id_ex_m,
    output logic [3:0]  id_ex_ex
);

    // Supported primary opcodes
    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;

    localparam int unsigned C_NREGS = 32;

    // ------------------------------------------------------------------------
    // Instruction field split
    // ------------------------------------------------------------------------
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;

    assign w_opcode = if_id_ir[31:26];
    assign w_rs     = if_id_ir[25:21];
    assign w_rt     = if_id_ir[20:16];
    assign w_rd     = if_id_ir[15:11];
    assign w_imm    = if_id_ir[15:0];

    // A write-back only takes effect when enabled and not aimed at r0
    logic w_wb_en;
    assign w_wb_en = wb_regwrite && (wb_wreg != 5'd0);

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    logic [31:0] rf_q [C_NREGS];

    // Register-file write port; reset clears every entry and drops any
    // write-back presented during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_NREGS; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (w_wb_en) begin
            rf_q[wb_wreg] <= wb_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Operand read with same-cycle write-through from write-back.
    // r0 reads as zero regardless of the stored value or any forwarding.
    // ------------------------------------------------------------------------
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    // rs read port
    always_comb begin
        w_rs_val = rf_q[w_rs];
        if (w_rs == 5'd0) begin
            w_rs_val = 32'd0;
        end else if (w_wb_en && (wb_wreg == w_rs)) begin
            w_rs_val = wb_wdata;
        end
    end

    // rt read port
    always_comb begin
        w_rt_val = rf_q[w_rt];
        if (w_rt == 5'd0) begin
            w_rt_val = 32'd0;
        end else if (w_wb_en && (wb_wreg == w_rt)) begin
            w_rt_val = wb_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Sign extension
    // ------------------------------------------------------------------------
    logic [31:0] w_imm_ext;
    assign w_imm_ext = {{16{w_imm[15]}}, w_imm};

    // ------------------------------------------------------------------------
    // Main control decode
    // ------------------------------------------------------------------------
    logic       w_regdst;
    logic       w_alusrc;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_branch;
    logic [1:0] w_aluop;

    // Opcode to control-signal decode; unknown opcodes become no-ops
    always_comb begin
        w_regdst   = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = 2'b00;
        case (w_opcode)
            C_OP_RTYPE: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_aluop    = 2'b10;
            end
            C_OP_LW: begin
                w_alusrc   = 1'b1;
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
            end
            C_OP_SW: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            C_OP_BEQ: begin
                w_branch   = 1'b1;
                w_aluop    = 2'b01;
            end
            default: begin
                w_aluop    = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // ID/EX next-state: a flush turns the instruction into a bubble by
    // clearing only the control groups; data fields still flow through.
    // ------------------------------------------------------------------------
    logic [1:0] wb_d;
    logic [2:0] m_d;
    logic [3:0] ex_d;

    // Control-group packing with flush override
    always_comb begin
        wb_d = {w_regwrite, w_memtoreg};
        m_d  = {w_branch, w_memread, w_memwrite};
        ex_d = {w_regdst, w_aluop, w_alusrc};
        if (flush) begin
            wb_d = 2'b00;
            m_d  = 3'b000;
            ex_d = 4'b0000;
        end
    end

    logic [31:0] npc_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] imm_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [1:0]  wb_q;
    logic [2:0]  m_q;
    logic [3:0]  ex_q;

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            npc_q <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            imm_q <= 32'd0;
            rt_q  <= 5'd0;
            rd_q  <= 5'd0;
            wb_q  <= 2'b00;
            m_q   <= 3'b000;
            ex_q  <= 4'b0000;
        end else begin
            npc_q <= if_id_npc;
            a_q   <= w_rs_val;
            b_q   <= w_rt_val;
            imm_q <= w_imm_ext;
            rt_q  <= w_rt;
            rd_q  <= w_rd;
            wb_q  <= wb_d;
            m_q   <= m_d;
            ex_q  <= ex_d;
        end
    end

    assign id_ex_npc = npc_q;
    assign id_ex_a   = a_q;
    assign id_ex_b   = b_q;
    assign id_ex_imm = imm_q;
    assign id_ex_rt  = rt_q;
    assign id_ex_rd  = rd_q;
    assign id_ex_wb  = wb_q;
    assign id_ex_m   = m_q;
    assign id_ex_ex  = ex_q;

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage MIPS pipeline. It sits directly downstream of the instruction-fetch stage and consumes that stage's IF/ID outputs: the fetched instruction and the incremented next-PC. It holds the 32x32 register file, sign-extends the 16-bit immediate and generates the main control word. All results are captured into the ID/EX pipeline register on each rising clock edge for the execute stage.

## Interface
Parameters:
- none; all widths are fixed by the 32-bit MIPS datapath.

Ports:
- clk  in  1  pipeline clock; every state element updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- if_id_ir  in  32  instruction from the IF/ID register
- if_id_npc  in  32  PC+4 from the IF/ID register
- flush  in  1  synchronous bubble request; zeroes the control fields captured into ID/EX
- wb_regwrite  in  1  write-back enable from the MEM/WB stage
- wb_wreg  in  5  write-back destination register number
- wb_wdata  in  32  write-back data
- id_ex_npc  out  32  registered copy of if_id_npc
- id_ex_a  out  32  registered rs operand
- id_ex_b  out  32  registered rt operand
- id_ex_imm  out  32  registered sign-extended ir[15:0]
- id_ex_rt  out  5  registered ir[20:16]
- id_ex_rd  out  5  registered ir[15:11]
- id_ex_wb  out  2  registered {RegWrite, MemtoReg}
- id_ex_m  out  3  registered {Branch, MemRead, MemWrite}
- id_ex_ex  out  4  registered {RegDst, ALUOp[1:0], ALUSrc}

## Operation
- Field split of the instruction:
  - opcode = ir[31:26]
  - rs = ir[25:21]
  - rt = ir[20:16]
  - rd = ir[15:11]
  - imm = ir[15:0]
- Register file:
  - 32 entries of 32 bits.
  - Written on the rising edge of clk when wb_regwrite=1 and wb_wreg!=0.
  - Writes to register 0 are discarded; a read of register 0 always returns 0.
- Register reads are combinational with write-through forwarding:
  - If wb_regwrite=1, wb_wreg!=0 and wb_wreg equals the register being read, the read returns wb_wdata in the same cycle.
  - This applies to the rs and rt ports independently.
- Sign extension: imm_ext = {16{ir[15]}, ir[15:0]}.
- Control decode, listed as RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp:
  - opcode 0x00 (R-type): 1,0,0,1,0,0,0,10
  - opcode 0x23 (lw): 0,1,1,1,1,0,0,00
  - opcode 0x2B (sw): 0,1,0,0,0,1,0,00
  - opcode 0x04 (beq): 0,0,0,0,0,0,1,01
  - any other opcode: all zero, so the instruction proceeds as a no-op.
- ID/EX register, on each rising edge of clk:
  - Captures npc, A, B, imm_ext, rt, rd and the decoded control word.
  - When flush=1, id_ex_wb, id_ex_m and id_ex_ex are loaded with 0. The data fields still capture normally.
- Priority: rst over flush over normal capture.

## Timing
- Reset:
  - rst=1 immediately, without waiting for a clock edge, forces every id_ex_* output to 0 and every register-file entry to 0.
  - rst asserted in mid-operation discards any pending write-back in that cycle.
  - The first capture occurs on the first rising edge after rst deasserts.
- Latency: one cycle. An instruction present on if_id_ir before edge N appears decoded on the id_ex_* outputs after edge N.
- Write-back and read of the same register in the same cycle:
  - The forwarded wb_wdata is what gets captured into ID/EX at the edge.
  - The register file is also updated at that edge.
- The outputs change only on a clock edge or on reset, never combinationally with the inputs.
- There is no stall or handshake; the stage accepts a new instruction every cycle.

## Test plan
- Reset: preload registers via write-back, then assert rst between clock edges -> all id_ex_* outputs are 0 at once, and a subsequent read of register 5 returns 0.
- R-type decode: write r1=0x11, r2=0x22, then apply ir=0x00221820 (add r3,r1,r2) with npc=0x8 -> after one edge:
  - id_ex_a=0x11, id_ex_b=0x22
  - id_ex_rd=3, id_ex_rt=2
  - id_ex_wb=2'b10, id_ex_m=3'b000, id_ex_ex=4'b1100
  - id_ex_npc=0x8
- lw with a negative immediate: ir=0x8C22FFFC -> id_ex_imm=0xFFFFFFFC, id_ex_wb=2'b11, id_ex_m=3'b010, id_ex_ex=4'b0001.
- Same-cycle forwarding: wb_regwrite=1, wb_wreg=1, wb_wdata=0xDEADBEEF while ir reads rs=1 -> id_ex_a=0xDEADBEEF after the edge. With wb_wreg=0 instead -> a write to r0 is ignored and a read of r0 yields 0.
- Flush and unknown opcodes:
  - beq instruction with flush=1 -> all control outputs are 0, while id_ex_npc and the operand fields still update.
  - ir=0xA00000AA (unsupported opcode) -> all control outputs are 0.
- Back-to-back instructions: a sw followed by a beq on consecutive cycles -> the outputs are id_ex_m=3'b001 and then 3'b100 on consecutive edges, with no bubble between them.
